strobe_sched: RTL and testbench

- Programmable strobe scheduler: generates single-cycle clock-enable strobes at a configurable period.
- Runs either continuously or as a finite burst.
- Provides a one-cycle-delayed copy of each strobe for downstream pipeline stages.
- Sits ahead of strobe-driven counters/datapaths and sequences when they advance.

---
 rtl/strobe_pkg.sv | 12 +
 rtl/strobe_div.sv | 48 ++++
 rtl/strobe_sched.sv | 113 +++++++++++
 tb/tb_strobe_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_pkg.sv
// Shared types and default widths for the strobe scheduler.
package strobe_pkg;

  localparam int unsigned PERIOD_W_DEF = 8;
  localparam int unsigned BURST_W_DEF  = 4;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } sched_state_t;

endpackage

// File: rtl/strobe_div.sv
// Loadable down-counter divider: ticks once every latched-period cycles while enabled.
module strobe_div
  import strobe_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                en_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign tick_o     = en_i && (cnt_q == '0);

  // The load cycle itself emits a strobe, so the counter holds cycles until the next one.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      period_d = period_eff;
      cnt_d    = period_eff - PERIOD_W'(1);
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d = period_q - PERIOD_W'(1);
      end else begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/strobe_sched.sv
// Programmable strobe scheduler (continuous or burst). Define STROBE_SCHED_RETRIGGER_EN
// to let start restart an active run.
module strobe_sched
  import strobe_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned BURST_W  = BURST_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [BURST_W-1:0]  burst_len_i,
  output logic                strobe_out_o,
  output logic                strobe_out_q_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [BURST_W-1:0]  strobe_count_o
);

`ifdef STROBE_SCHED_RETRIGGER_EN
  localparam bit Retrigger = 1'b1;
`else
  localparam bit Retrigger = 1'b0;
`endif

  sched_state_t       state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               strobe_dly_q;
  logic               div_load, div_en, div_tick;

  strobe_div #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (div_load),
    .period_i (period_i),
    .en_i     (div_en),
    .tick_o   (div_tick)
  );

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d  = StRun;
          burst_d  = burst_len_i;
          count_d  = BURST_W'(1);
          strobe_d = 1'b1;
          div_load = 1'b1;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (Retrigger && start_i) begin
          burst_d  = burst_len_i;
          count_d  = BURST_W'(1);
          strobe_d = 1'b1;
          div_load = 1'b1;
        end else if ((burst_q != '0) && (count_q == burst_q)) begin
          // The final strobe went out on the previous edge; this edge completes the burst.
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          div_en = 1'b1;
          if (div_tick) begin
            strobe_d = 1'b1;
            count_d  = count_q + BURST_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      burst_q      <= '0;
      count_q      <= '0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      strobe_dly_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      count_q      <= count_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      strobe_dly_q <= strobe_q;
    end
  end

  assign strobe_out_o   = strobe_q;
  assign strobe_out_q_o = strobe_dly_q;
  assign busy_o         = (state_q == StRun);
  assign done_o         = done_q;
  assign strobe_count_o = count_q;

endmodule

// File: tb/tb_strobe_sched.sv
// Self-checking bench for strobe_sched: directed table, corner sequences, random vs model.
module tb_strobe_sched;

`ifdef STROBE_SCHED_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [7:0] period;
  logic [3:0] burst_len;
  logic       strobe_out, strobe_out_q, busy, done;
  logic [3:0] strobe_count;

  int n_chk  = 0;
  int n_fail = 0;

  strobe_sched #(
    .PERIOD_W (8),
    .BURST_W  (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .period_i       (period),
    .burst_len_i    (burst_len),
    .strobe_out_o   (strobe_out),
    .strobe_out_q_o (strobe_out_q),
    .busy_o         (busy),
    .done_o         (done),
    .strobe_count_o (strobe_count)
  );

  always #5 clk = ~clk;

  // Reference model: strobes fall on edges whose offset from the start edge is a multiple of P.
  bit m_run, m_strobe, m_dly, m_done;
  int m_cnt, m_b, m_p, m_s, m_e;

  function automatic void model_reset();
    m_run = 0; m_strobe = 0; m_dly = 0; m_done = 0; m_cnt = 0; m_b = 0; m_p = 1; m_s = 0;
  endfunction

  function automatic void begin_run(int per, int bl);
    m_run = 1; m_s = m_e; m_p = (per == 0) ? 1 : per; m_b = bl; m_strobe = 1; m_cnt = 1;
  endfunction

  function automatic void model_step(bit st, bit sp, int per, int bl);
    bit prev;
    prev     = m_strobe;
    m_done   = 0;
    m_strobe = 0;
    if (!m_run) begin
      if (st && !sp) begin_run(per, bl);
    end else if (sp) begin
      m_run = 0;
    end else if (RETRIG && st) begin
      begin_run(per, bl);
    end else if (m_b != 0 && m_cnt == m_b) begin
      m_run  = 0;
      m_done = 1;
    end else if (((m_e - m_s) % m_p) == 0) begin
      m_strobe = 1;
      m_cnt    = (m_cnt + 1) % 16;
    end
    m_dly = prev;
    m_e++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".strobe"}, 32'(strobe_out), 32'(m_strobe));
    chk({tag, ".strobe_q"}, 32'(strobe_out_q), 32'(m_dly));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".count"}, 32'(strobe_count), 32'(m_cnt));
  endtask

  // Drive inputs, take one edge (model follows), then settle past the edge.
  task automatic step(input bit st, input bit sp, input int per, input int bl);
    start     = st;
    stop      = sp;
    period    = 8'(per);
    burst_len = 4'(bl);
    @(posedge clk);
    model_step(st, sp, per, bl);
    #1;
  endtask

  typedef struct {
    bit st, sp;
    int per, bl;
    bit s, sq, bu, d;
    int cnt;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, int per, int bl, bit s, bit sq, bit bu, bit d,
                              int cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.bl = bl;
    v.s = s; v.sq = sq; v.bu = bu; v.d = d; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(1, 0, 3, 4, 1, 0, 1, 0, 1);
    tbl[1]  = mk(0, 0, 3, 4, 0, 1, 1, 0, 1);
    tbl[2]  = mk(0, 0, 3, 4, 0, 0, 1, 0, 1);
    tbl[3]  = mk(0, 0, 3, 4, 1, 0, 1, 0, 2);
    tbl[4]  = mk(0, 0, 3, 4, 0, 1, 1, 0, 2);
    tbl[5]  = mk(0, 0, 3, 4, 0, 0, 1, 0, 2);
    tbl[6]  = mk(0, 0, 3, 4, 1, 0, 1, 0, 3);
    tbl[7]  = mk(0, 0, 3, 4, 0, 1, 1, 0, 3);
    tbl[8]  = mk(0, 0, 3, 4, 0, 0, 1, 0, 3);
    tbl[9]  = mk(0, 0, 3, 4, 1, 0, 1, 0, 4);
    tbl[10] = mk(0, 0, 3, 4, 0, 1, 0, 1, 4);
    tbl[11] = mk(0, 0, 3, 4, 0, 0, 0, 0, 4);
    tbl[12] = mk(1, 1, 2, 2, 0, 0, 0, 0, 4);
    tbl[13] = mk(1, 0, 2, 2, 1, 0, 1, 0, 1);
    tbl[14] = mk(0, 0, 2, 2, 0, 1, 1, 0, 1);
    tbl[15] = mk(0, 0, 2, 2, 1, 0, 1, 0, 2);
    tbl[16] = mk(0, 1, 2, 2, 0, 1, 0, 0, 2);
    tbl[17] = mk(0, 0, 2, 2, 0, 0, 0, 0, 2);

    model_reset();
    m_e = 0;
    rst_n = 1'b0; start = 0; stop = 0; period = 0; burst_len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.strobe", 32'(strobe_out), 0);
    chk("rst.strobe_q", 32'(strobe_out_q), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.count", 32'(strobe_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: burst p=3 b=4, then start+stop in IDLE, then stop on completion edge.
    for (int i = 0; i < 18; i++) begin
      string t;
      step(tbl[i].st, tbl[i].sp, tbl[i].per, tbl[i].bl);
      t = $sformatf("tbl%0d", i);
      chk({t, ".strobe"}, 32'(strobe_out), 32'(tbl[i].s));
      chk({t, ".strobe_q"}, 32'(strobe_out_q), 32'(tbl[i].sq));
      chk({t, ".busy"}, 32'(busy), 32'(tbl[i].bu));
      chk({t, ".done"}, 32'(done), 32'(tbl[i].d));
      chk({t, ".count"}, 32'(strobe_count), 32'(tbl[i].cnt));
    end

    // Continuous, period 0 -> every cycle; count wraps; stop at run edge 20.
    step(1, 0, 0, 0);
    chk_model("cont0");
    for (int j = 1; j < 20; j++) begin
      step(0, 0, 0, 0);
      chk_model($sformatf("cont%0d", j));
      if (j == 14) chk("cont.count15", 32'(strobe_count), 15);
      if (j == 15) chk("cont.wrap0", 32'(strobe_count), 0);
      chk("cont.done_low", 32'(done), 0);
    end
    step(0, 1, 0, 0);
    chk("contstop.strobe", 32'(strobe_out), 0);
    chk("contstop.busy", 32'(busy), 0);
    chk("contstop.done", 32'(done), 0);
    chk_model("contstop");
    step(0, 0, 0, 0);
    chk_model("contstop1");

    // Period change mid-run is ignored; next run picks up the new period.
    step(1, 0, 3, 0);
    for (int j = 1; j < 10; j++) begin
      step(0, 0, (j >= 2) ? 7 : 3, 0);
      chk($sformatf("pchg%0d.strobe", j), 32'(strobe_out), 32'(j % 3 == 0));
      chk_model($sformatf("pchg%0d", j));
    end
    step(0, 1, 7, 0);
    chk_model("pchg.stop");
    step(1, 0, 7, 3);
    chk_model("p7.0");
    for (int j = 1; j < 17; j++) begin
      step(0, 0, 7, 3);
      chk_model($sformatf("p7.%0d", j));
      if (j < 15) chk($sformatf("p7.%0d.strobe", j), 32'(strobe_out), 32'(j % 7 == 0));
      if (j == 15) chk("p7.done", 32'(done), 1);
    end

    // start while running with period 5.
    step(1, 0, 5, 0);
    step(0, 0, 5, 0);
    step(0, 0, 5, 0);
    step(1, 0, 5, 0);
    chk("retrig.strobe", 32'(strobe_out), RETRIG ? 1 : 0);
    chk("retrig.count", 32'(strobe_count), 1);
    chk_model("retrig");
    for (int j = 4; j < 12; j++) begin
      step(0, 0, 5, 0);
      chk_model($sformatf("retrig%0d", j));
    end
    if (!RETRIG) begin
      step(0, 0, 5, 0);
      chk("retrig.cadence", 32'(strobe_out), 0);
    end

    // Asynchronous reset between edges.
    step(0, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.strobe", 32'(strobe_out), 0);
    chk("arst.strobe_q", 32'(strobe_out_q), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.count", 32'(strobe_count), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 2, 0);
    chk_model("arst.idle");

    // Random stimulus against the model.
    for (int j = 0; j < 400; j++) begin
      step($urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(6), $urandom_range(5));
      chk_model($sformatf("rnd%0d", j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
